// File: rtl/bus_mem_responder.sv
// bus_mem_responder: shared 256x8 memory serving two cache controllers.
// Each port latches one pending request on the rising edge of its strobe. A three-state FSM
// (Idle/Access/Done) serves one request at a time with round-robin tie-breaking. Writes
// raise a one-cycle invalidate strobe to the other cache.
//
// Ports:
//   CC_clk, rst                        clock, asynchronous active-high reset
//   bus_access_0/1                     request strobes (rising edge = new request)
//   write_opn_to_bus_0/1               1 = write, 0 = read
//   read_select_Mem_0/1                read address
//   write_select_Mem_0/1               write address
//   write_data_Mem_0/1                 write data
//   finish_0/1                         one-cycle completion pulse to the requester
//   out_data_Mem                       read data; holds until the next read completes
//   flag_snoop_0/1, snoop_address      invalidate strobe and address of the last write
//   grant_id                           port currently being served
module bus_mem_responder #(
  // Memory access cycles per request, legal range 1..7.
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       CC_clk,
  input  logic       rst,
  input  logic       bus_access_0,
  input  logic       bus_access_1,
  input  logic       write_opn_to_bus_0,
  input  logic       write_opn_to_bus_1,
  input  logic [7:0] read_select_Mem_0,
  input  logic [7:0] read_select_Mem_1,
  input  logic [7:0] write_select_Mem_0,
  input  logic [7:0] write_select_Mem_1,
  input  logic [7:0] write_data_Mem_0,
  input  logic [7:0] write_data_Mem_1,
  output logic       finish_0,
  output logic       finish_1,
  output logic [7:0] out_data_Mem,
  output logic       flag_snoop_0,
  output logic       flag_snoop_1,
  output logic [7:0] snoop_address,
  output logic       grant_id
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [2:0] LastCnt = 3'(MEM_LATENCY - 1);

  logic [1:0] acc_in, wr_in;
  logic [7:0] rd_sel [2];
  logic [7:0] wr_sel [2];
  logic [7:0] wr_dat [2];

  assign acc_in    = {bus_access_1, bus_access_0};
  assign wr_in     = {write_opn_to_bus_1, write_opn_to_bus_0};
  assign rd_sel[0] = read_select_Mem_0;
  assign rd_sel[1] = read_select_Mem_1;
  assign wr_sel[0] = write_select_Mem_0;
  assign wr_sel[1] = write_select_Mem_1;
  assign wr_dat[0] = write_data_Mem_0;
  assign wr_dat[1] = write_data_Mem_1;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic [1:0] acc_q, rise, capture, grant_oh;
  logic [1:0] pend_q, pend_wr_q;
  logic [7:0] pend_addr_q [2];
  logic [7:0] pend_data_q [2];

  logic [1:0] finish_q, finish_d, snoop_q, snoop_d;
  logic [7:0] out_data_q, out_data_d, snoop_addr_q, snoop_addr_d;
  logic [7:0] mem_q [256];

  logic       go_done, cur_wr;
  logic [7:0] cur_addr, cur_data;

  assign rise     = acc_in & ~acc_q;
  assign grant_oh = grant_q ? 2'b10 : 2'b01;
  // A full slot ignores new edges, except in its own Done cycle where the refill wins.
  assign capture  = rise & (~pend_q | ((state_q == StDone) ? grant_oh : 2'b00));
  assign cur_wr   = pend_wr_q[grant_q];
  assign cur_addr = pend_addr_q[grant_q];
  assign cur_data = pend_data_q[grant_q];
  assign go_done  = (state_q == StAccess) && (cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          grant_d = (&pend_q) ? ~last_grant_q : pend_q[1];
          cnt_d   = 3'd0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) state_d = StDone;
        else                  cnt_d   = cnt_q + 3'd1;
      end
      StDone: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered on the Access->Done edge so they are valid in the Done cycle.
  always_comb begin
    finish_d     = 2'b00;
    snoop_d      = 2'b00;
    out_data_d   = out_data_q;
    snoop_addr_d = snoop_addr_q;
    if (go_done) begin
      finish_d = grant_oh;
      if (cur_wr) begin
        snoop_d      = ~grant_oh;
        snoop_addr_d = cur_addr;
      end else begin
        out_data_d = mem_q[cur_addr];
      end
    end
  end

  always_ff @(posedge CC_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      finish_q     <= 2'b00;
      snoop_q      <= 2'b00;
      out_data_q   <= 8'h00;
      snoop_addr_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      finish_q     <= finish_d;
      snoop_q      <= snoop_d;
      out_data_q   <= out_data_d;
      snoop_addr_q <= snoop_addr_d;
    end
  end

  always_ff @(posedge CC_clk or posedge rst) begin
    if (rst) begin
      acc_q     <= 2'b00;
      pend_q    <= 2'b00;
      pend_wr_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        pend_addr_q[p] <= 8'h00;
        pend_data_q[p] <= 8'h00;
      end
    end else begin
      acc_q <= acc_in;
      for (int p = 0; p < 2; p++) begin
        if (capture[p]) begin
          pend_q[p]      <= 1'b1;
          pend_wr_q[p]   <= wr_in[p];
          pend_addr_q[p] <= wr_in[p] ? wr_sel[p] : rd_sel[p];
          pend_data_q[p] <= wr_dat[p];
        end else if ((state_q == StDone) && grant_oh[p]) begin
          pend_q[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CC_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else if (go_done && cur_wr) begin
      mem_q[cur_addr] <= cur_data;
    end
  end

  assign finish_0      = finish_q[0];
  assign finish_1      = finish_q[1];
  assign flag_snoop_0  = snoop_q[0];
  assign flag_snoop_1  = snoop_q[1];
  assign out_data_Mem  = out_data_q;
  assign snoop_address = snoop_addr_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder. Stimulus pushes expected completions (in expected
// service order) into a queue; a monitor pops one entry per finish pulse and compares.
// A second instance with MEM_LATENCY=1 covers the short-latency write case.
module tb_bus_mem_responder;
  localparam int unsigned ML = 2;

  logic CC_clk = 1'b0;
  logic rst = 1'b1;
  always #5 CC_clk = ~CC_clk;

  int cyc = 0;
  always @(posedge CC_clk) cyc <= cyc + 1;

  logic       bus_access_0 = 0, bus_access_1 = 0;
  logic       write_opn_to_bus_0 = 0, write_opn_to_bus_1 = 0;
  logic [7:0] read_select_Mem_0 = 0, read_select_Mem_1 = 0;
  logic [7:0] write_select_Mem_0 = 0, write_select_Mem_1 = 0;
  logic [7:0] write_data_Mem_0 = 0, write_data_Mem_1 = 0;
  logic       finish_0, finish_1, flag_snoop_0, flag_snoop_1, grant_id;
  logic [7:0] out_data_Mem, snoop_address;

  logic       b_acc_0 = 0, b_acc_1 = 0, b_wr_0 = 0, b_wr_1 = 0;
  logic [7:0] b_rsel_0 = 0, b_rsel_1 = 0, b_wsel_0 = 0, b_wsel_1 = 0, b_wdat_0 = 0, b_wdat_1 = 0;
  logic       b_fin_0, b_fin_1, b_snp_0, b_snp_1, b_gnt;
  logic [7:0] b_out, b_saddr;

  bus_mem_responder #(.MEM_LATENCY(ML)) dut (
    .CC_clk(CC_clk), .rst(rst),
    .bus_access_0(bus_access_0), .bus_access_1(bus_access_1),
    .write_opn_to_bus_0(write_opn_to_bus_0), .write_opn_to_bus_1(write_opn_to_bus_1),
    .read_select_Mem_0(read_select_Mem_0), .read_select_Mem_1(read_select_Mem_1),
    .write_select_Mem_0(write_select_Mem_0), .write_select_Mem_1(write_select_Mem_1),
    .write_data_Mem_0(write_data_Mem_0), .write_data_Mem_1(write_data_Mem_1),
    .finish_0(finish_0), .finish_1(finish_1), .out_data_Mem(out_data_Mem),
    .flag_snoop_0(flag_snoop_0), .flag_snoop_1(flag_snoop_1),
    .snoop_address(snoop_address), .grant_id(grant_id)
  );

  bus_mem_responder #(.MEM_LATENCY(1)) dut1 (
    .CC_clk(CC_clk), .rst(rst),
    .bus_access_0(b_acc_0), .bus_access_1(b_acc_1),
    .write_opn_to_bus_0(b_wr_0), .write_opn_to_bus_1(b_wr_1),
    .read_select_Mem_0(b_rsel_0), .read_select_Mem_1(b_rsel_1),
    .write_select_Mem_0(b_wsel_0), .write_select_Mem_1(b_wsel_1),
    .write_data_Mem_0(b_wdat_0), .write_data_Mem_1(b_wdat_1),
    .finish_0(b_fin_0), .finish_1(b_fin_1), .out_data_Mem(b_out),
    .flag_snoop_0(b_snp_0), .flag_snoop_1(b_snp_1),
    .snoop_address(b_saddr), .grant_id(b_gnt)
  );

  typedef struct {
    bit         port;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem_m [256];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per finish pulse.
  initial begin
    exp_t       e;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] last_wa = 8'h00;
    bit         prev_fin = 0;
    forever begin
      @(negedge CC_clk);
      if (rst) begin
        last_rd  = 8'h00;
        last_wa  = 8'h00;
        prev_fin = 0;
      end else if (finish_0 || finish_1) begin
        chk("finish_pulse_len", 32'(prev_fin), 0);
        if (sbq.size() == 0) begin
          chk("unexpected_finish", {finish_1, finish_0}, 0);
        end else begin
          e = sbq.pop_front();
          chk("finish_port", {finish_1, finish_0}, e.port ? 2 : 1);
          chk("grant_id", 32'(grant_id), 32'(e.port));
          if (e.exp_cyc >= 0) chk("finish_latency", cyc, e.exp_cyc);
          if (e.wr) begin
            chk("snoop_flags", {flag_snoop_1, flag_snoop_0}, e.port ? 1 : 2);
            chk("snoop_address", snoop_address, e.addr);
            chk("read_data_hold", out_data_Mem, last_rd);
            last_wa = e.addr;
          end else begin
            chk("read_data", out_data_Mem, e.data);
            chk("no_snoop_on_read", {flag_snoop_1, flag_snoop_0}, 0);
            chk("snoop_addr_hold", snoop_address, last_wa);
            last_rd = e.data;
          end
        end
        prev_fin = 1;
      end else begin
        if (flag_snoop_0 || flag_snoop_1) chk("stray_snoop", {flag_snoop_1, flag_snoop_0}, 0);
        prev_fin = 0;
      end
    end
  end

  task automatic drive(input bit p, input bit wr, input logic [7:0] a, input logic [7:0] d);
    // The unused address carries the complement to expose a wrong address mux.
    if (!p) begin
      bus_access_0 = 1; write_opn_to_bus_0 = wr; write_data_Mem_0 = d;
      read_select_Mem_0 = wr ? ~a : a; write_select_Mem_0 = wr ? a : ~a;
    end else begin
      bus_access_1 = 1; write_opn_to_bus_1 = wr; write_data_Mem_1 = d;
      read_select_Mem_1 = wr ? ~a : a; write_select_Mem_1 = wr ? a : ~a;
    end
  endtask

  task automatic push(input bit p, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input int ec);
    exp_t e;
    e.port = p; e.wr = wr; e.addr = a; e.exp_cyc = ec;
    if (wr) begin
      mem_m[a] = d;
      e.data   = d;
    end else begin
      e.data = mem_m[a];
    end
    sbq.push_back(e);
  endtask

  task automatic drop();
    bus_access_0 = 0;
    bus_access_1 = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge CC_clk);
      n++;
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
    repeat (6) @(negedge CC_clk);
  endtask

  // Uncontended single transaction with a one-cycle strobe; capture is the next posedge.
  task automatic txn(input bit p, input bit wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge CC_clk);
    drive(p, wr, a, d);
    push(p, wr, a, d, cyc + 1 + int'(ML) + 1);
    @(negedge CC_clk);
    drop();
    wait_done(40);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_finish", {finish_1, finish_0}, 0);
    chk("rst_snoop", {flag_snoop_1, flag_snoop_0}, 0);
    chk("rst_out_data", out_data_Mem, 0);
    chk("rst_snoop_addr", snoop_address, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    sbq.delete();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    repeat (2) @(negedge CC_clk);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge CC_clk);
    do_reset();
    @(negedge CC_clk);

    // Read after reset returns zero with the nominal latency.
    txn(0, 0, 8'h10, 8'h00);
    // Write snoops the other port; the other port then reads it back.
    txn(0, 1, 8'h2A, 8'h5C);
    txn(1, 0, 8'h2A, 8'h00);

    // Second edge on a pending port is ignored.
    @(negedge CC_clk);
    n = cyc;
    drive(1, 0, 8'h2A, 8'h00);
    push(1, 0, 8'h2A, 8'h00, n + 4);
    @(negedge CC_clk); drop();
    @(negedge CC_clk); drive(1, 0, 8'h10, 8'h00);
    @(negedge CC_clk); drop();
    wait_done(40);

    // An edge in the port's own Done cycle is captured as a new request.
    @(negedge CC_clk);
    n = cyc;
    drive(0, 0, 8'h2A, 8'h00);
    push(0, 0, 8'h2A, 8'h00, n + 4);
    @(negedge CC_clk); drop();
    repeat (3) @(negedge CC_clk);
    drive(0, 1, 8'h44, 8'h77);
    push(0, 1, 8'h44, 8'h77, n + 8);
    @(negedge CC_clk); drop();
    wait_done(40);
    txn(1, 0, 8'h44, 8'h00);

    // Simultaneous pair straight after reset: port 0 first.
    do_reset();
    @(negedge CC_clk);
    n = cyc;
    drive(0, 1, 8'h20, 8'h3C);
    drive(1, 0, 8'h20, 8'h00);
    push(0, 1, 8'h20, 8'h3C, n + 4);
    push(1, 0, 8'h20, 8'h00, n + 8);
    @(negedge CC_clk); drop();
    wait_done(40);
    // Port 0 served last, so the next simultaneous pair goes to port 1 first.
    txn(0, 0, 8'h20, 8'h00);
    @(negedge CC_clk);
    n = cyc;
    drive(0, 1, 8'h80, 8'hA5);
    drive(1, 0, 8'h80, 8'h00);
    push(1, 0, 8'h80, 8'h00, n + 4);
    push(0, 1, 8'h80, 8'hA5, n + 8);
    @(negedge CC_clk); drop();
    wait_done(40);
    txn(1, 0, 8'h80, 8'h00);

    // Reset during Access aborts the write: no finish, no snoop, memory untouched.
    @(negedge CC_clk);
    drive(0, 1, 8'h33, 8'hFF);
    @(negedge CC_clk); drop();
    @(negedge CC_clk);
    do_reset();
    repeat (8) @(negedge CC_clk);
    txn(0, 0, 8'h33, 8'h00);

    // MEM_LATENCY=1 instance: one-cycle write strobe on port 1.
    @(negedge CC_clk);
    b_acc_1 = 1; b_wr_1 = 1; b_wsel_1 = 8'hFF; b_rsel_1 = 8'h00; b_wdat_1 = 8'h01;
    @(negedge CC_clk);
    b_acc_1 = 0;
    chk("l1_no_early_finish_a", {b_fin_1, b_fin_0}, 0);
    @(negedge CC_clk);
    chk("l1_no_early_finish_b", {b_fin_1, b_fin_0}, 0);
    @(negedge CC_clk);
    chk("l1_finish", {b_fin_1, b_fin_0}, 2);
    chk("l1_snoop", {b_snp_1, b_snp_0}, 1);
    chk("l1_snoop_addr", b_saddr, 8'hFF);
    @(negedge CC_clk);
    chk("l1_finish_one_cycle", {b_fin_1, b_fin_0, b_snp_1, b_snp_0}, 0);
    b_acc_0 = 1; b_wr_0 = 0; b_rsel_0 = 8'hFF; b_wsel_0 = 8'h00;
    @(negedge CC_clk);
    b_acc_0 = 0;
    repeat (2) @(negedge CC_clk);
    chk("l1_read_finish", {b_fin_1, b_fin_0}, 1);
    chk("l1_read_data", b_out, 8'h01);
    chk("l1_read_no_snoop", {b_snp_1, b_snp_0}, 0);
    repeat (4) @(negedge CC_clk);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
